// File: rtl/hilo_div_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU writing {remainder, quotient} to HI/LO.
// Optional macro DIV_EARLY_EXIT_EN: skip iterations when |dividend| < |divisor|.
module hilo_div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  stallreq_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_W-1:0]     rem_q;
    logic [DATA_W-1:0]     quo_q;
    logic [DATA_W-1:0]     dvsr_q;
    logic                  neg1_q;
    logic                  neg2_q;
    logic                  sgn_q;
    logic [2*DATA_W-1:0]   result_q;
    logic                  ready_q;

    logic                  op1_neg_s;
    logic                  op2_neg_s;
    logic [DATA_W-1:0]     abs1_s;
    logic [DATA_W-1:0]     abs2_s;
    logic [DATA_W:0]       trial_s;
    logic [DATA_W-1:0]     rem_d;
    logic [DATA_W-1:0]     quo_d;
    logic [CNT_W-1:0]      cnt_d;
    logic [DATA_W-1:0]     rem_fix_s;
    logic [DATA_W-1:0]     quo_fix_s;

    function automatic logic [DATA_W-1:0] neg_if(input logic en, input logic [DATA_W-1:0] v);
        neg_if = en ? (~v + DATA_W'(1)) : v;
    endfunction

    // Operand magnitudes and one restoring iteration on the latched state.
    always_comb begin
        op1_neg_s = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg_s = signed_div_i & opdata2_i[DATA_W-1];
        abs1_s    = neg_if(op1_neg_s, opdata1_i);
        abs2_s    = neg_if(op2_neg_s, opdata2_i);
        // DATA_W+1 bits suffice: the shifted remainder is always below 2*divisor.
        trial_s   = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvsr_q};
        if (trial_s[DATA_W]) begin
            rem_d = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
        end else begin
            rem_d = trial_s[DATA_W-1:0];
        end
        quo_d     = {quo_q[DATA_W-2:0], ~trial_s[DATA_W]};
        cnt_d     = cnt_q + CNT_W'(1);
        quo_fix_s = neg_if(sgn_q & (neg1_q ^ neg2_q), quo_d);
        rem_fix_s = neg_if(sgn_q & neg1_q, rem_d);
    end

    // Divide FSM with registered result and ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            rem_q    <= {DATA_W{1'b0}};
            quo_q    <= {DATA_W{1'b0}};
            dvsr_q   <= {DATA_W{1'b0}};
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            sgn_q    <= 1'b0;
            result_q <= {(2*DATA_W){1'b0}};
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q  <= 1'b0;
                    result_q <= {(2*DATA_W){1'b0}};
                    if (start_i && !annul_i) begin
                        if (opdata2_i == {DATA_W{1'b0}}) begin
                            state_q <= S_BYZERO;
`ifdef DIV_EARLY_EXIT_EN
                        end else if (abs1_s < abs2_s) begin
                            state_q  <= S_END;
                            result_q <= {opdata1_i, {DATA_W{1'b0}}};
                            ready_q  <= 1'b1;
`endif
                        end else begin
                            state_q <= S_ON;
                            cnt_q   <= {CNT_W{1'b0}};
                            rem_q   <= {DATA_W{1'b0}};
                            quo_q   <= abs1_s;
                            dvsr_q  <= abs2_s;
                            neg1_q  <= op1_neg_s;
                            neg2_q  <= op2_neg_s;
                            sgn_q   <= signed_div_i;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BYZERO: begin
                    if (annul_i) begin
                        state_q  <= S_IDLE;
                        ready_q  <= 1'b0;
                        result_q <= {(2*DATA_W){1'b0}};
                    end else begin
                        state_q  <= S_END;
                        ready_q  <= 1'b1;
                        result_q <= {(2*DATA_W){1'b0}};
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state_q  <= S_IDLE;
                        ready_q  <= 1'b0;
                        result_q <= {(2*DATA_W){1'b0}};
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == CNT_W'(DATA_W)) begin
                            state_q  <= S_END;
                            result_q <= {rem_fix_s, quo_fix_s};
                            ready_q  <= 1'b1;
                        end else begin
                            state_q <= S_ON;
                        end
                    end
                end
                S_END: begin
                    if (annul_i || !start_i) begin
                        state_q  <= S_IDLE;
                        ready_q  <= 1'b0;
                        result_q <= {(2*DATA_W){1'b0}};
                    end else begin
                        state_q <= S_END;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    ready_q  <= 1'b0;
                    result_q <= {(2*DATA_W){1'b0}};
                end
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign busy_o     = (state_q != S_IDLE);
    assign stallreq_o = start_i & ~ready_q;

endmodule

// File: doc/hilo_div_seq.md
Name: hilo_div_seq

Overview:
- Multi-cycle radix-2 restoring divider and its sequencer, serving DIV/DIVU issued by the execute stage.
- Execute presents the operands and holds start_i. It stalls the pipeline on stallreq_o and captures result_o into HI/LO when ready_o rises.
- HI receives the remainder, LO the quotient.
- The block owns the divide FSM, the iteration counter, sign fix-up, divide-by-zero handling and abort on pipeline flush.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  request; held high by execute until ready_o has been seen.
- annul_i  input  1  flush/exception; abort the current operation.
- result_o  output  2*DATA_W  {remainder, quotient}, registered.
- ready_o  output  1  result valid, registered.
- busy_o  output  1  FSM not in IDLE.
- stallreq_o  output  1  combinational: start_i & ~ready_o.

Behaviour:
- Reset: rst high at an edge forces state IDLE, cnt=0, result_o=0, ready_o=0. Reset mid-operation discards all work.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - Operands are captured at the start edge only.
  - start_i=1, annul_i=0, divisor==0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. Latch |dividend|, |divisor| (two's-complement negation only when signed_div_i and MSB=1), both sign bits and signed_div_i. Clear cnt and the partial remainder.
  - Otherwise stay in IDLE.
- ON, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - Trial subtract = rem_shifted - |divisor|, computed DATA_W+1 wide.
  - If not negative: rem = difference, quo LSB = 1. Otherwise keep rem, quo LSB = 0.
  - cnt increments each iteration. After DATA_W iterations (cnt==DATA_W) -> END.
- Sign fix-up on entry to END:
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend was negative.
  - result_o = {rem, quo}. ready_o goes 1.
- BYZERO: next cycle -> END with result_o=0, ready_o=1.
- END:
  - Hold result_o and ready_o while start_i=1.
  - start_i=0 -> IDLE, with ready_o=0 and result_o=0 in the same cycle.
- annul_i=1 in BYZERO, ON or END -> IDLE next edge, ready_o=0, result_o=0. annul_i in IDLE blocks start.
- Simultaneous annul_i and the final iteration: annul wins and no ready is produced.
- Latency: start_i sampled at edge 0.
  - Normal operation: ready_o is high from edge DATA_W+1, i.e. 33 cycles.
  - Divide-by-zero: ready_o is high from edge 2.
- Overflow case: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap is raised.
- Operand changes on opdata*_i after the start edge are ignored.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined: in IDLE on a valid start with divisor!=0 and |dividend| < |divisor|, go directly to END. result_o = {dividend as given, 0} and ready_o is high from edge 1.
- Undefined: this case runs the full DATA_W iterations and yields the identical result.

Test Plan:
- DIVU 100 / 7, start held -> ready_o high 33 cycles after start, result_o = {32'd2, 32'd14}; stallreq_o high cycles 0..32, then low.
- DIV -7 / 2 (0xFFFFFFF9 / 2) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; DIV 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}; DIVU 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}.
- Divisor 0 (DIVU 5 / 0) -> BYZERO, ready_o at edge 2, result_o = 0. Dropping start_i afterwards -> IDLE, ready_o=0 the next cycle.
- annul_i pulsed at iteration 10, then rst pulsed mid-operation of a second divide -> each returns to IDLE next edge, ready_o never asserts, result_o=0, and a following start runs normally.
- DIV_EARLY_EXIT_EN defined: DIVU 3 / 10 -> ready_o at edge 1, result_o = {3, 0}. Undefined: same result at 33 cycles.
